// File: rtl/cosim_trace_queue.sv
// Elastic 2-in/2-out retire-trace queue feeding the cosim checker.
// Ports: clock/reset(async low); in_{0,1}_* retire slots; drain_en;
//   in_ready; out_{0,1}_* registered lanes; out_cycle; out_hartid;
//   overflow (sticky); drop_count (saturating).
module cosim_trace_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter logic [63:0] HARTID = 64'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_0_valid,
   input  logic [63:0] in_0_iaddr,
   input  logic [31:0] in_0_insn,
   input  logic        in_0_exception,
   input  logic        in_0_interrupt,
   input  logic [63:0] in_0_cause,
   input  logic        in_0_has_wdata,
   input  logic [63:0] in_0_wdata,
   input  logic [2:0]  in_0_priv,
   input  logic        in_1_valid,
   input  logic [63:0] in_1_iaddr,
   input  logic [31:0] in_1_insn,
   input  logic        in_1_exception,
   input  logic        in_1_interrupt,
   input  logic [63:0] in_1_cause,
   input  logic        in_1_has_wdata,
   input  logic [63:0] in_1_wdata,
   input  logic [2:0]  in_1_priv,
   input  logic        drain_en,
   output logic        in_ready,
   output logic        out_0_valid,
   output logic [63:0] out_0_iaddr,
   output logic [31:0] out_0_insn,
   output logic        out_0_exception,
   output logic        out_0_interrupt,
   output logic [63:0] out_0_cause,
   output logic        out_0_has_wdata,
   output logic [63:0] out_0_wdata,
   output logic [2:0]  out_0_priv,
   output logic        out_1_valid,
   output logic [63:0] out_1_iaddr,
   output logic [31:0] out_1_insn,
   output logic        out_1_exception,
   output logic        out_1_interrupt,
   output logic [63:0] out_1_cause,
   output logic        out_1_has_wdata,
   output logic [63:0] out_1_wdata,
   output logic [2:0]  out_1_priv,
   output logic [63:0] out_cycle,
   output logic [63:0] out_hartid,
   output logic        overflow,
   output logic [31:0] drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic        valid;
      logic [63:0] iaddr;
      logic [31:0] insn;
      logic        exception;
      logic        interrupt;
      logic [63:0] cause;
      logic        has_wdata;
      logic [63:0] wdata;
      logic [2:0]  priv;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        e0, e1;
   entry_t        lane0_q, lane0_d, lane1_q, lane1_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, rd1, wr1;
   logic [AW:0]   count_q, count_d;
   logic [AW+1:0] room;
   logic [1:0]    pop, n_acc, n_drop;
   logic          ev0, ev1, acc0, acc1;
   logic [63:0]   cyc_q, out_cycle_q;
   logic          ovf_q;
   logic [31:0]   drop_q;
   logic [32:0]   drop_sum;

   always_comb begin
      e0 = {in_0_valid, in_0_iaddr, in_0_insn, in_0_exception,
            in_0_interrupt, in_0_cause, in_0_has_wdata,
            in_0_wdata, in_0_priv};
      e1 = {in_1_valid, in_1_iaddr, in_1_insn, in_1_exception,
            in_1_interrupt, in_1_cause, in_1_has_wdata,
            in_1_wdata, in_1_priv};
      ev0 = in_0_valid | in_0_exception | in_0_interrupt;
      ev1 = in_1_valid | in_1_exception | in_1_interrupt;
      pop = 2'd0;
      if (drain_en)
         pop = (count_q >= (AW+1)'(2)) ? 2'd2 : count_q[1:0];
      // Slots popped this cycle free their room for this cycle's pushes.
      room = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(pop);
      acc0 = ev0 && (room != '0);
      // Slot 1 is only accepted behind slot 0, never ahead of a drop.
      acc1 = ev1 && (room >= (ev0 ? (AW+2)'(2) : (AW+2)'(1)));
      n_acc  = {1'b0, acc0} + {1'b0, acc1};
      n_drop = {1'b0, ev0 & ~acc0} + {1'b0, ev1 & ~acc1};
      wr1 = wr_q + AW'(acc0);
      rd1 = rd_q + AW'(1);
      wr_d = wr_q + AW'(n_acc);
      rd_d = rd_q + AW'(pop);
      count_d = count_q + (AW+1)'(n_acc) - (AW+1)'(pop);
      lane0_d = '0;
      lane1_d = '0;
      if (pop != 2'd0) lane0_d = mem_q[rd_q];
      if (pop == 2'd2) lane1_d = mem_q[rd1];
      drop_sum = {1'b0, drop_q} + 33'(n_drop);
   end

   always_ff @(posedge clock) begin
      if (acc0) mem_q[wr_q] <= e0;
      if (acc1) mem_q[wr1]  <= e1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_q        <= '0;
         wr_q        <= '0;
         count_q     <= '0;
         lane0_q     <= '0;
         lane1_q     <= '0;
         cyc_q       <= '0;
         out_cycle_q <= '0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
      end else begin
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         count_q     <= count_d;
         lane0_q     <= lane0_d;
         lane1_q     <= lane1_d;
         cyc_q       <= cyc_q + 64'd1;
         out_cycle_q <= cyc_q;
         if (n_drop != 2'd0) ovf_q <= 1'b1;
         drop_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
   end

   assign in_ready   = count_q <= (AW+1)'(DEPTH - 2);
   assign out_cycle  = out_cycle_q;
   assign out_hartid = HARTID;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

   assign out_0_valid     = lane0_q.valid;
   assign out_0_iaddr     = lane0_q.iaddr;
   assign out_0_insn      = lane0_q.insn;
   assign out_0_exception = lane0_q.exception;
   assign out_0_interrupt = lane0_q.interrupt;
   assign out_0_cause     = lane0_q.cause;
   assign out_0_has_wdata = lane0_q.has_wdata;
   assign out_0_wdata     = lane0_q.wdata;
   assign out_0_priv      = lane0_q.priv;
   assign out_1_valid     = lane1_q.valid;
   assign out_1_iaddr     = lane1_q.iaddr;
   assign out_1_insn      = lane1_q.insn;
   assign out_1_exception = lane1_q.exception;
   assign out_1_interrupt = lane1_q.interrupt;
   assign out_1_cause     = lane1_q.cause;
   assign out_1_has_wdata = lane1_q.has_wdata;
   assign out_1_wdata     = lane1_q.wdata;
   assign out_1_priv      = lane1_q.priv;

endmodule
